// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter/timer family.
// Used by modn_updown_counter and other timer blocks.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Width of next-state arithmetic: one guard bit above the counter width.
    function automatic int unsigned ext_width(input int unsigned width);
        return width + 1;
    endfunction

    function automatic logic [32:0] clamp_load(input logic [32:0] value,
                                               input logic [32:0] modulus);
        logic [32:0] max_val;
        max_val = modulus - 33'd1;
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/modn_updown_counter_dff_bank.sv
// WIDTH-bit D-register bank, synchronous active-low reset to zero.
module dff_bank #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) q <= '0;
        else        q <= d;
    end

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with load, registered wrap pulse and sticky flag.
// Build option COUNTER_SATURATE_EN: saturate at the bounds instead of wrapping.
module modn_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH   = 4,
    parameter longint unsigned  MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flag,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             wrap_flag,
    output logic             at_max,
    output logic             at_zero
);

    localparam int unsigned      EXT_W = ext_width(WIDTH);
    localparam logic [EXT_W-1:0] MAX_X = EXT_W'(MODULUS - 64'd1);
    localparam logic [EXT_W-1:0] ONE_X = EXT_W'(1);

    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_param_check
        $fatal(1, "modn_updown_counter: illegal WIDTH/MODULUS combination");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [EXT_W-1:0] count_x;
    logic [EXT_W-1:0] next_x;
    logic             is_max;
    logic             is_zero;
    logic             wrap_d;
    logic             wrap_q;
    logic             wrap_flag_q;

    dff_bank #(
        .WIDTH (WIDTH)
    ) u_count_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (count_d),
        .q     (count_q)
    );

    assign count_x = EXT_W'(count_q);
    assign is_max  = (count_x == MAX_X);
    assign is_zero = (count_q == '0);

`ifdef COUNTER_SATURATE_EN
    // Set once a step past the bound has been pulsed; cleared when the count moves or reloads.
    logic sat_q;
    logic sat_d;

    always_comb begin
        next_x = count_x;
        wrap_d = 1'b0;
        sat_d  = sat_q;
        if (load) begin
            next_x = EXT_W'(clamp_load(33'(load_val), 33'(MODULUS)));
            sat_d  = 1'b0;
        end else if (enable) begin
            if ((up_dn == DIR_UP && is_max) || (up_dn == DIR_DOWN && is_zero)) begin
                wrap_d = ~sat_q;
                sat_d  = 1'b1;
            end else begin
                next_x = (up_dn == DIR_UP) ? count_x + ONE_X : count_x - ONE_X;
                sat_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) sat_q <= 1'b0;
        else        sat_q <= sat_d;
    end
`else
    always_comb begin
        next_x = count_x;
        wrap_d = 1'b0;
        if (load) begin
            next_x = EXT_W'(clamp_load(33'(load_val), 33'(MODULUS)));
        end else if (enable) begin
            if (up_dn == DIR_UP) begin
                if (is_max) begin
                    next_x = '0;
                    wrap_d = 1'b1;
                end else begin
                    next_x = count_x + ONE_X;
                end
            end else begin
                if (is_zero) begin
                    next_x = MAX_X;
                    wrap_d = 1'b1;
                end else begin
                    next_x = count_x - ONE_X;
                end
            end
        end
    end
`endif

    assign count_d = WIDTH'(next_x);

    // Set wins over clear when a wrap and clr_flag coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrap_q      <= 1'b0;
            wrap_flag_q <= 1'b0;
        end else begin
            wrap_q      <= wrap_d;
            wrap_flag_q <= wrap_d | (wrap_flag_q & ~clr_flag);
        end
    end

    assign count     = count_q;
    assign wrap      = wrap_q;
    assign wrap_flag = wrap_flag_q;
    assign at_max    = is_max;
    assign at_zero   = is_zero;

endmodule
